vgacon_tty: RTL

- Terminal-style front end for the VGA text console. It accepts a stream of characters over a valid/ready handshake.
- It keeps a cursor and translates control codes (CR, LF, BS, FF) into writes on the console's text-buffer write port. It also performs hardware scroll and clear.
- It sits directly upstream of the text buffer and drives cells in the same 10-bit format: {color[2:0], char[6:0]}.

---
 rtl/vgacon_pkg.sv | 34 +++
 rtl/vgacon_tty.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vgacon_pkg.sv
// Shared geometry, blank-cell, control-code and FSM-state definitions for the
// VGA text console front end.
package vgacon_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 10;
  localparam int ADDR_W   = $clog2(NUM_ROWS * NUM_COLS);

  // BLANK_COLOR matches the console's default text color.
  localparam logic [6:0] BLANK_CHAR  = 7'h20;
  localparam logic [2:0] BLANK_COLOR = 3'b010;

  localparam logic [6:0] CC_BS = 7'h08;
  localparam logic [6:0] CC_LF = 7'h0A;
  localparam logic [6:0] CC_FF = 7'h0C;
  localparam logic [6:0] CC_CR = 7'h0D;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SCROLL    = 2'd1;
  localparam logic [1:0] ST_FILL_LAST = 2'd2;
  localparam logic [1:0] ST_CLEAR_ALL = 2'd3;

  typedef logic [1:0] state_t;

  typedef struct packed {
    logic [2:0] color;
    logic [6:0] ch;
  } cell_t;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/vgacon_tty.sv
// Terminal front end: cursor tracking, control codes, hardware scroll and clear
// driving the text-buffer write port. One character per cycle when idle.
module vgacon_tty #(
  parameter int         NUM_ROWS    = vgacon_pkg::NUM_ROWS,
  parameter int         NUM_COLS    = vgacon_pkg::NUM_COLS,
  parameter int         ADDR_W      = $clog2(NUM_ROWS * NUM_COLS),
  parameter logic [6:0] BLANK_CHAR  = vgacon_pkg::BLANK_CHAR,
  parameter logic [2:0] BLANK_COLOR = vgacon_pkg::BLANK_COLOR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  in_char,
  input  logic [2:0]                  in_color,
  output logic                        buf_we,
  output logic [ADDR_W-1:0]           buf_waddr,
  output logic [9:0]                  buf_wdata,
  output logic [ADDR_W-1:0]           buf_raddr,
  input  logic [9:0]                  buf_rdata,
  output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
  output logic [$clog2(NUM_COLS)-1:0] cursor_col,
  output logic                        busy
);
  import vgacon_pkg::*;

  localparam int RW       = $clog2(NUM_ROWS);
  localparam int CW       = $clog2(NUM_COLS);
  localparam int CELLS    = NUM_ROWS * NUM_COLS;
  localparam int SCROLL_N = (NUM_ROWS - 1) * NUM_COLS;

  localparam logic [RW-1:0]     LAST_ROW   = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0]     LAST_COL   = CW'(NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'(SCROLL_N - 1);
  localparam logic [ADDR_W-1:0] FILL_END   = ADDR_W'(NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] CLEAR_END  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'(SCROLL_N);
  localparam cell_t             BLANK      = '{color: BLANK_COLOR, ch: BLANK_CHAR};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_k;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  cell_t               r_wdata;
  logic                r_drain;

  logic                w_ready;
  logic                w_accept;
  logic                w_printable;
  logic [ADDR_W-1:0]   w_cur_addr;

  // r_drain holds off new input while the final scroll/clear write is on the bus.
  assign w_ready     = (r_state == ST_IDLE) && !r_drain;
  assign w_accept    = in_valid && w_ready;
  assign w_printable = is_printable(in_char);
  assign w_cur_addr  = ADDR_W'(r_row) * ADDR_W'(NUM_COLS) + ADDR_W'(r_col);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_drain <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_drain <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_we    <= 1'b1;
              r_waddr <= w_cur_addr;
              r_wdata <= '{color: in_color, ch: in_char};
              if (r_col == LAST_COL) begin
                r_col <= '0;
                if (r_row == LAST_ROW) begin
                  r_state <= ST_SCROLL;
                  r_k     <= '0;
                end else begin
                  r_row <= r_row + RW'(1);
                end
              end else begin
                r_col <= r_col + CW'(1);
              end
            end else begin
              case (in_char)
                CC_CR: r_col <= '0;
                CC_LF: begin
                  r_col <= '0;
                  if (r_row == LAST_ROW) begin
                    r_state <= ST_SCROLL;
                    r_k     <= '0;
                  end else begin
                    r_row <= r_row + RW'(1);
                  end
                end
                CC_BS: begin
                  if (r_col != '0) r_col <= r_col - CW'(1);
                end
                CC_FF: begin
                  r_row   <= '0;
                  r_col   <= '0;
                  r_state <= ST_CLEAR_ALL;
                  r_k     <= '0;
                end
                default: ;
              endcase
            end
          end
        end

        // Row r+1 is read combinationally and lands in row r one cycle later.
        ST_SCROLL: begin
          r_we    <= 1'b1;
          r_waddr <= r_k;
          r_wdata <= buf_rdata;
          if (r_k == SCROLL_END) begin
            r_state <= ST_FILL_LAST;
            r_k     <= '0;
          end else begin
            r_k <= r_k + ADDR_W'(1);
          end
        end

        ST_FILL_LAST: begin
          r_we    <= 1'b1;
          r_waddr <= LAST_BASE + r_k;
          r_wdata <= BLANK;
          if (r_k == FILL_END) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_drain <= 1'b1;
          end else begin
            r_k <= r_k + ADDR_W'(1);
          end
        end

        ST_CLEAR_ALL: begin
          r_we    <= 1'b1;
          r_waddr <= r_k;
          r_wdata <= BLANK;
          if (r_k == CLEAR_END) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_drain <= 1'b1;
          end else begin
            r_k <= r_k + ADDR_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign busy       = !w_ready;
  assign buf_we     = r_we;
  assign buf_waddr  = r_waddr;
  assign buf_wdata  = r_wdata;
  assign buf_raddr  = (r_state == ST_SCROLL) ? (r_k + ADDR_W'(NUM_COLS)) : '0;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

endmodule
